bram_pixel_fifo: RTL and testbench

- Parametrised single-clock FIFO built on inferred block RAM. It is the successor to the fixed 1024x4 pixel RAM wrapper.
- Generalised data width and depth. Adds pointer management, full/empty/almost-full flags, fill level, sticky error flags and a synchronous flush.
- Sits between the OV7670 capture path (writer) and the VGA pixel fetch (reader) when both run in the pixel clock domain. It is the line-buffer/elastic store.

---
 rtl/bram_pixel_fifo.sv | 123 ++++++++++++
 tb/tb_bram_pixel_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bram_pixel_fifo.sv
// Single-clock pixel FIFO on inferred block RAM with level, almost-full and sticky error flags.
// Define BRAM_PIXEL_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle request/response.
module bram_pixel_fifo #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 10,
    parameter int AFULL_TH = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AFULL_L = (ADDR_W+1)'(AFULL_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic              active, wr_acc, ram_rd, rd_reject, empty_nxt, full_nxt;

    // Flush (reset or clear) blocks every request in the same cycle.
    assign active     = rst_n && !clear;
    assign wr_acc     = active && wr_en && !full;
    assign rd_reject  = active && rd_en && empty;
    assign wr_ptr_nxt = wr_ptr + (ADDR_W+1)'(wr_acc);
    assign rd_ptr_nxt = rd_ptr + (ADDR_W+1)'(ram_rd);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

`ifndef BRAM_PIXEL_FIFO_FWFT_EN
    assign ram_rd    = active && rd_en && !empty;
    assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    assign full_nxt  = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                       (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);

    always_ff @(posedge clk) begin
        if (!active) begin
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
        end else begin
            rd_data_vld <= ram_rd;
            if (ram_rd) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end
`else
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] ram_q;
    logic              pend, pop, move, out_vld_nxt;

    // RAM read stage (pend/ram_q) feeds the head register (rd_data/rd_data_vld).
    assign pop         = active && rd_en && rd_data_vld;
    assign move        = pend && (!rd_data_vld || pop);
    assign ram_rd      = active && (wr_ptr != rd_ptr) && (!pend || move);
    assign out_vld_nxt = move || (rd_data_vld && !pop);
    // level counts every stored word, including those already fetched out of the RAM.
    assign level_nxt   = level + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(pop);
    assign empty_nxt   = !out_vld_nxt;
    assign full_nxt    = (level_nxt == DEPTH_L);

    always_ff @(posedge clk) begin
        if (ram_rd) begin
            ram_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!active) begin
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
            pend        <= 1'b0;
        end else begin
            pend        <= ram_rd || (pend && !move);
            rd_data_vld <= out_vld_nxt;
            if (move) begin
                rd_data <= ram_q;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!active) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            level       <= level_nxt;
            empty       <= empty_nxt;
            full        <= full_nxt;
            almost_full <= (level_nxt >= AFULL_L);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_reject) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bram_pixel_fifo.sv
// Randomized bench for bram_pixel_fifo (default 1-cycle read mode) against a queue-based reference model.
module tb_bram_pixel_fifo;
    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int AFULL_TH = 1000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [DATA_W-1:0] rd_data;
    logic              full, almost_full, rd_data_vld, empty, overflow, underflow;
    logic [ADDR_W:0]   level;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_data;
    logic              m_vld, m_ovf, m_unf;

    bram_pixel_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
        .empty(empty), .level(level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        m_data = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_all();
        check("level", 32'(level), 32'(exp_q.size()));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("almost_full", 32'(almost_full), 32'(exp_q.size() >= AFULL_TH));
        check("rd_data_vld", 32'(rd_data_vld), 32'(m_vld));
        check("rd_data", 32'(rd_data), 32'(m_data));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    // One clock: drive requests, advance the model at the edge, compare just after it.
    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
        bit m_full, m_empty;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clear   = c;
        @(posedge clk);
        m_full  = (exp_q.size() == DEPTH);
        m_empty = (exp_q.size() == 0);
        if (!rst_n || c) begin
            model_flush();
        end else begin
            m_vld = 1'b0;
            if (r && !m_empty) begin
                m_data = exp_q.pop_front();
                m_vld  = 1'b1;
            end
            if (r && m_empty) m_unf = 1'b1;
            if (w && !m_full) exp_q.push_back(d);
            if (w && m_full) m_ovf = 1'b1;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        model_flush();

        // Reset state
        do_reset();
        check("reset_level", 32'(level), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);

        // 0x1..0xA in, then back-to-back reads
        for (int i = 1; i <= 10; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("seq_data", 32'(rd_data), 32'(i));
        end
        step(1'b0, '0, 1'b0, 1'b0);
        check("seq_end_level", 32'(level), 32'd0);

        // Read on empty
        step(1'b0, '0, 1'b1, 1'b0);
        check("underflow_set", 32'(underflow), 32'd1);
        check("underflow_no_vld", 32'(rd_data_vld), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Fill to full, then one dropped write
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'(DEPTH));
        step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        check("overflow_set", 32'(overflow), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Drain to 37 with overflow set, then clear with requests that must be ignored
        while (exp_q.size() > 37) step(1'b0, '0, 1'b1, 1'b0);
        check("pre_clear_level", 32'(level), 32'd37);
        step(1'b1, 4'h5, 1'b1, 1'b1);
        check("clear_level", 32'(level), 32'd0);
        check("clear_overflow", 32'(overflow), 32'd0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_clear_data", 32'(rd_data), 32'h9);

        // Reset in the middle of a read must cancel its valid
        step(1'b1, 4'h3, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 4'h7, 1'b1, 1'b0);
        rst_n = 1'b1;
        check("midreset_vld", 32'(rd_data_vld), 32'd0);

        // Half-full streaming: pointers wrap several times, level must hold
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            step(1'b1, DATA_W'($urandom), 1'b1, 1'b0);
            check("stream_level", 32'(level), 32'(DEPTH / 2));
        end

        // Random traffic with occasional clears
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
